// File: rtl/vga_timing_gen.sv
// Pixel-rate VGA timing generator: free-running h/v counters with registered
// sync, display-enable, active coordinates and line/frame start pulses.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        H_POL    = 1'b0,
  parameter logic        V_POL    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       de_q, de_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  // Outputs are decoded from the next counter values so they land in the
  // same edge as the counters themselves.
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (pix_en) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end

      hsync_d = (hcount_d >= HS_FIRST && hcount_d <= HS_LAST) ? H_POL : ~H_POL;
      vsync_d = (vcount_d >= VS_FIRST && vcount_d <= VS_LAST) ? V_POL : ~V_POL;
      de_d    = (hcount_d < H_VIS) && (vcount_d < V_VIS);
      x_d     = de_d ? hcount_d : '0;
      y_d     = de_d ? vcount_d : '0;

      line_start_d  = (hcount_d == '0);
      frame_start_d = (hcount_d == '0) && (vcount_d == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount_q      <= H_LAST;
      vcount_q      <= V_LAST;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (30x15) so whole frames fit
// in a short run; a queue-fed monitor checks every edge, directed checks measure periods.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4, HT = 30;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3, VT = 15;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
  } out_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_en;
  logic       hsync, vsync, de, line_start, frame_start;
  logic [9:0] x, y;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  out_t sbq[$];
  bit   enq[$];
  int   ls_q[$];

  int cyc = 0;
  int hs_low = 0, vs_low = 0, de_cnt = 0, ls_cnt = 0, fs_cnt = 0;
  int xmax = 0, ymax = 0;

  int m_h, m_v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic out_t dut_out();
    out_t o;
    o = '{hs: hsync, vs: vsync, de: de, ls: line_start, fs: frame_start, x: x, y: y};
    return o;
  endfunction

  function automatic out_t model_out(input int h, input int v, input bit en);
    out_t o;
    o.hs = !(h >= HA + HF && h <= HA + HF + HS - 1);
    o.vs = !(v >= VA + VF && v <= VA + VF + VS - 1);
    o.de = (h < HA) && (v < VA);
    o.x  = o.de ? 10'(h) : 10'd0;
    o.y  = o.de ? 10'(v) : 10'd0;
    o.ls = en && (h == 0);
    o.fs = en && (h == 0) && (v == 0);
    return o;
  endfunction

  task automatic model_reset();
    m_h = HT - 1;
    m_v = VT - 1;
  endtask

  // Drive one clock worth of pix_en and queue what that edge must produce.
  task automatic step(input bit en);
    @(negedge clk);
    pix_en = en;
    if (en) begin
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
    sbq.push_back(model_out(m_h, m_v, en));
    enq.push_back(en);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset(input string nm);
    out_t r;
    r = '{hs: 1'b1, vs: 1'b1, de: 1'b0, ls: 1'b0, fs: 1'b0, x: 10'd0, y: 10'd0};
    chk(nm, 32'(dut_out()), 32'(r));
  endtask

  task automatic chk_first_edge(input string nm);
    out_t r;
    r = '{hs: 1'b1, vs: 1'b1, de: 1'b1, ls: 1'b1, fs: 1'b1, x: 10'd0, y: 10'd0};
    chk(nm, 32'(dut_out()), 32'(r));
  endtask

  task automatic chk_intervals(input string nm, input int base, input int req);
    int mn, mx;
    mn = 1 << 30;
    mx = 0;
    for (int i = base + 1; i < ls_q.size(); i++) begin
      if (ls_q[i] - ls_q[i-1] < mn) mn = ls_q[i] - ls_q[i-1];
      if (ls_q[i] - ls_q[i-1] > mx) mx = ls_q[i] - ls_q[i-1];
    end
    chk({nm, "_min"}, 32'(mn), 32'(req));
    chk({nm, "_max"}, 32'(mx), 32'(req));
  endtask

  // Monitor: one queued expectation per driven edge.
  initial begin
    out_t e;
    bit   en;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (sbq.size() > 0) begin
        e  = sbq.pop_front();
        en = enq.pop_front();
        chk("sb_outputs", 32'(dut_out()), 32'(e));
        if (line_start) begin
          ls_cnt++;
          ls_q.push_back(cyc);
        end
        if (frame_start) fs_cnt++;
        if (en) begin
          if (!hsync) hs_low++;
          if (!vsync) vs_low++;
          if (de) begin
            de_cnt++;
            if (int'(x) > xmax) xmax = int'(x);
            if (int'(y) > ymax) ymax = int'(y);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_ls, b_fs, b_hs, b_vs, b_de, b_q, guard;
    reset  = 1'b1;
    pix_en = 1'b0;
    model_reset();

    #1;
    chk_reset("reset_async");
    repeat (3) @(posedge clk);
    #2;
    chk_reset("reset_hold");

    @(negedge clk);
    reset = 1'b0;
    step(1'b0);
    step(1'b1);
    settle();
    chk_first_edge("first_edge");

    // Two full frames at half rate: 900 enabled edges.
    b_ls = ls_cnt; b_fs = fs_cnt; b_hs = hs_low; b_vs = vs_low; b_de = de_cnt; b_q = ls_q.size();
    for (int i = 0; i < 900; i++) begin
      step(1'b0);
      step(1'b1);
    end
    settle();
    chk("tog_line_starts",  32'(ls_cnt - b_ls), 32'd30);
    chk("tog_frame_starts", 32'(fs_cnt - b_fs), 32'd2);
    chk("tog_hsync_low",    32'(hs_low - b_hs), 32'd180);
    chk("tog_vsync_low",    32'(vs_low - b_vs), 32'd120);
    chk("tog_de_pixels",    32'(de_cnt - b_de), 32'd256);
    chk("x_last_active",    32'(xmax), 32'd15);
    chk("y_last_active",    32'(ymax), 32'd7);
    chk_intervals("tog_line_period", b_q, 60);

    // Mid-line stall of 100 clocks: nothing may move or pulse.
    repeat (7) step(1'b1);
    settle();
    b_ls = ls_cnt; b_fs = fs_cnt;
    repeat (100) step(1'b0);
    settle();
    chk("stall_line_starts",  32'(ls_cnt - b_ls), 32'd0);
    chk("stall_frame_starts", 32'(fs_cnt - b_fs), 32'd0);

    // pix_en stuck high for one frame's worth of clocks.
    b_ls = ls_cnt; b_fs = fs_cnt; b_q = ls_q.size();
    repeat (450) step(1'b1);
    settle();
    chk("full_line_starts",  32'(ls_cnt - b_ls), 32'd15);
    chk("full_frame_starts", 32'(fs_cnt - b_fs), 32'd1);
    chk_intervals("full_line_period", b_q, 30);

    // Reset asserted inside the hsync pulse (hcount 23 of 20..25).
    guard = 0;
    while (m_h != 23 && guard < HT * VT) begin
      step(1'b1);
      guard++;
    end
    settle();
    chk("hsync_before_reset", 32'(hsync), 32'd0);
    #1;
    reset  = 1'b1;
    pix_en = 1'b0;
    model_reset();
    #1;
    chk_reset("reset_mid_sync");
    settle();
    chk_reset("reset_mid_hold");
    @(negedge clk);
    reset = 1'b0;
    step(1'b0);
    step(1'b1);
    settle();
    chk_first_edge("restart_edge");
    repeat (40) step(1'b1);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter H_POL, default 0, active level of hsync.
REQ-010 SHALL have parameter V_POL, default 0, active level of vsync.
REQ-011 SHALL have port clk, input, 1 bit, 50 MHz system clock.
REQ-012 SHALL have port reset, input, 1 bit, reset, asynchronous, active-high.
REQ-013 SHALL have port pix_en, input, 1 bit, pixel-rate enable from the 25 MHz divider, high every other clk.
REQ-014 SHALL have port hsync, output, 1 bit, horizontal sync.
REQ-015 SHALL have port vsync, output, 1 bit, vertical sync.
REQ-016 SHALL have port de, output, 1 bit, display enable (active video).
REQ-017 SHALL have port x, output, 10 bits, active pixel column.
REQ-018 SHALL have port y, output, 10 bits, active pixel row.
REQ-019 SHALL have port line_start, output, 1 bit, one-clk pulse at start of each line.
REQ-020 SHALL have port frame_start, output, 1 bit, one-clk pulse at start of each frame.

Function
REQ-021 SHALL keep internal counters hcount, vcount, 10 bits each; H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-022 SHALL change counters and outputs only on rising clk edges where pix_en=1; with pix_en=0, all state and outputs SHALL hold, except the pulse outputs, which SHALL clear.
REQ-023 SHALL, on each enabled edge, advance hcount by 1, wrapping from H_TOTAL-1 to 0.
REQ-024 SHALL advance vcount by 1 only on the hcount wrap, wrapping from V_TOTAL-1 to 0; simultaneous h/v wrap SHALL give (0,0).
REQ-025 SHALL register all outputs in the same edge as the counter update, each a function of the new counter values (zero latency relative to the counters).
REQ-026 SHALL drive hsync = H_POL when new hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] ([656,751]), else ~H_POL.
REQ-027 SHALL drive vsync = V_POL when new vcount is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] ([490,491]), else ~V_POL; vsync SHALL depend only on vcount.
REQ-028 SHALL drive de=1 iff new hcount<H_ACTIVE and new vcount<V_ACTIVE.
REQ-029 SHALL drive x=hcount and y=vcount when de=1; x=0 and y=0 when de=0.
REQ-030 SHALL pulse line_start for exactly one clk when hcount becomes 0.
REQ-031 SHALL pulse frame_start for exactly one clk when (hcount,vcount) become (0,0); line_start SHALL pulse in the same clk.
REQ-032 SHALL treat pix_en held high continuously as valid, advancing every clk, with no lost or repeated counts.

Reset
REQ-033 SHALL, while reset=1, force hcount=H_TOTAL-1, vcount=V_TOTAL-1, hsync=~H_POL, vsync=~V_POL, de=0, x=0, y=0, line_start=0, frame_start=0, regardless of clk.
REQ-034 SHALL, on the first enabled edge after reset release, move to (0,0), assert frame_start and line_start, and set de=1, x=0, y=0.
REQ-035 SHALL, on reset asserted mid-frame, abandon the frame immediately with no partial sync pulse continuation.

Verification
REQ-036 Reset, release, pix_en toggling from 0 -> first enabled edge: frame_start=line_start=1 for one clk, de=1, x=0, y=0.
REQ-037 pix_en toggling, count enabled edges -> line_start every 800 enabled edges (1600 clk); frame_start every 420000 enabled edges.
REQ-038 Line 0 scan -> de high for hcount 0..639, x=639 at last active pixel, x=0 from hcount 640; hsync low exactly for hcount 656..751 (96 pixels).
REQ-039 Frame scan -> vsync low exactly for lines 490..491; de=0 for all of lines 480..524; y=479 on last active line.
REQ-040 pix_en stuck 0 for 100 clk mid-line -> all outputs hold, no pulses; pix_en stuck 1 -> counts advance every clk, line period 800 clk.
REQ-041 Reset pulsed at hcount=700 (within hsync) -> hsync=1, de=0 same cycle asynchronously; restart per REQ-034.
